mat_row_buf: RTL and testbench

// - Row-organised matrix store that sits directly upstream of lu / triang_matrix_inv.
// - Host loads a SIZE x SIZE complex matrix row by row, then start_o pulses to kick the engine.
// - Serves engine row reads (1-cycle latency) and accepts engine row write-backs.
// - Host then dumps the updated matrix row by row.
// - Replaces the ad-hoc row memory around the LU/inverse engines.

---
 rtl/mat_row_buf.sv | 160 ++++++++++++++++
 tb/tb_mat_row_buf.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_row_buf.sv
// Row-organised SIZE x SIZE complex matrix store between host and LU/inverse engine.
// Optional macro MAT_ROW_BUF_BYPASS_EN forwards a same-cycle write-back to the read port.
module mat_row_buf #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [SIZE*2*WIDTH-1:0]       ld_row_i,
  input  logic                          ld_valid_i,
  output logic                          ld_ready_o,
  output logic                          start_o,
  input  logic [$clog2(SIZE)-1:0]       rd_addr_i,
  input  logic                          rd_addr_valid_i,
  output logic [SIZE*2*WIDTH-1:0]       rd_row_o,
  output logic [$clog2(SIZE)-1:0]       rd_addr_o,
  output logic                          rd_valid_o,
  input  logic [SIZE*2*WIDTH-1:0]       wr_row_i,
  input  logic [$clog2(SIZE)-1:0]       wr_addr_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic                          dump_start_i,
  output logic [SIZE*2*WIDTH-1:0]       dump_row_o,
  output logic [$clog2(SIZE)-1:0]       dump_addr_o,
  output logic                          dump_valid_o,
  input  logic                          dump_ready_i,
  output logic                          busy_o
);

  localparam int ROW_W = SIZE*2*WIDTH;
  localparam int AW    = $clog2(SIZE);
  localparam logic [AW-1:0] LAST = AW'(SIZE-1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SERVE, S_DUMP} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_ld_cnt;
  logic             r_ld_ready;
  logic             r_wr_ready;
  logic             r_busy;
  logic             r_start;
  logic             r_rd_valid;
  logic [ROW_W-1:0] r_rd_row;
  logic [AW-1:0]    r_rd_addr;
  logic             r_dump_valid;
  logic [ROW_W-1:0] r_dump_row;
  logic [AW-1:0]    r_dump_addr;
  logic [ROW_W-1:0] r_mem [SIZE];

  logic             w_ld_hs;
  logic             w_ld_we;
  logic             w_wr_we;
  logic [ROW_W-1:0] w_rd_data;

  assign w_ld_hs = ld_valid_i & r_ld_ready;
  assign w_ld_we = rst_ni & ~flush_i & w_ld_hs;
  assign w_wr_we = rst_ni & ~flush_i & wr_valid_i & r_wr_ready;

`ifdef MAT_ROW_BUF_BYPASS_EN
  assign w_rd_data = (w_wr_we && (wr_addr_i == rd_addr_i)) ? wr_row_i : r_mem[rd_addr_i];
`else
  assign w_rd_data = r_mem[rd_addr_i];
`endif

  // Storage keeps its contents across reset and flush.
  always_ff @(posedge clk_i) begin
    if (w_ld_we) r_mem[r_ld_cnt] <= ld_row_i;
    if (w_wr_we) r_mem[wr_addr_i] <= wr_row_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_ld_cnt     <= '0;
      r_ld_ready   <= 1'b0;
      r_wr_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_start      <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_row     <= '0;
      r_rd_addr    <= '0;
      r_dump_valid <= 1'b0;
      r_dump_row   <= '0;
      r_dump_addr  <= '0;
    end else if (flush_i) begin
      r_state      <= S_IDLE;
      r_ld_cnt     <= '0;
      r_ld_ready   <= 1'b1;
      r_wr_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_start      <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_addr  <= '0;
    end else begin
      r_start    <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_LOAD: begin
          r_ld_ready <= 1'b1;
          if (w_ld_hs) begin
            r_busy <= 1'b1;
            if (r_ld_cnt == LAST) begin
              r_ld_cnt   <= '0;
              r_state    <= S_SERVE;
              r_start    <= 1'b1;
              r_ld_ready <= 1'b0;
              r_wr_ready <= 1'b1;
            end else begin
              r_ld_cnt <= r_ld_cnt + 1'b1;
              r_state  <= S_LOAD;
            end
          end
        end
        S_SERVE: begin
          r_rd_valid <= rd_addr_valid_i;
          if (rd_addr_valid_i) begin
            r_rd_row  <= w_rd_data;
            r_rd_addr <= rd_addr_i;
          end
          if (dump_start_i) begin
            r_state      <= S_DUMP;
            r_wr_ready   <= 1'b0;
            r_dump_valid <= 1'b1;
            r_dump_addr  <= '0;
            r_dump_row   <= r_mem[0];
          end
        end
        S_DUMP: begin
          // dump_valid_o is always high in DUMP, so ready alone completes a beat
          if (dump_ready_i) begin
            if (r_dump_addr == LAST) begin
              r_state      <= S_IDLE;
              r_dump_valid <= 1'b0;
              r_busy       <= 1'b0;
              r_ld_ready   <= 1'b1;
            end else begin
              r_dump_addr <= r_dump_addr + 1'b1;
              r_dump_row  <= r_mem[r_dump_addr + 1'b1];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld_ready_o   = r_ld_ready;
  assign start_o      = r_start;
  assign rd_row_o     = r_rd_row;
  assign rd_addr_o    = r_rd_addr;
  assign rd_valid_o   = r_rd_valid;
  assign wr_ready_o   = r_wr_ready;
  assign dump_row_o   = r_dump_row;
  assign dump_addr_o  = r_dump_addr;
  assign dump_valid_o = r_dump_valid;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_mat_row_buf.sv
// Self-checking bench for mat_row_buf: directed scenarios plus a randomized soak against a phase-level model.
module tb_mat_row_buf;
  localparam int SIZE  = 4;
  localparam int WIDTH = 64;
  localparam int ROW_W = SIZE*2*WIDTH;
  localparam int AW    = $clog2(SIZE);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [ROW_W-1:0] ld_row = '0;
  logic             ld_valid = 1'b0;
  logic             ld_ready;
  logic             start;
  logic [AW-1:0]    rd_addr = '0;
  logic             rd_av = 1'b0;
  logic [ROW_W-1:0] rd_row;
  logic [AW-1:0]    rd_addr_q;
  logic             rd_valid;
  logic [ROW_W-1:0] wr_row = '0;
  logic [AW-1:0]    wr_addr = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic             dump_start = 1'b0;
  logic [ROW_W-1:0] dump_row;
  logic [AW-1:0]    dump_addr;
  logic             dump_valid;
  logic             dump_ready = 1'b0;
  logic             busy;

  int total = 0;
  int bad = 0;

  mat_row_buf #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .ld_row_i(ld_row), .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .start_o(start),
    .rd_addr_i(rd_addr), .rd_addr_valid_i(rd_av), .rd_row_o(rd_row), .rd_addr_o(rd_addr_q),
    .rd_valid_o(rd_valid), .wr_row_i(wr_row), .wr_addr_i(wr_addr), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready), .dump_start_i(dump_start), .dump_row_o(dump_row),
    .dump_addr_o(dump_addr), .dump_valid_o(dump_valid), .dump_ready_i(dump_ready), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference row R_i: element j = (i+j) + 0.5j, real/imag as Q32.32 fixed point.
  function automatic logic [ROW_W-1:0] mkrow(input int i);
    logic [ROW_W-1:0] r;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    r = '0;
    for (int j = 0; j < SIZE; j++) begin
      re = WIDTH'(i + j) << 32;
      im = WIDTH'(64'h8000_0000);
      r[j*2*WIDTH +: 2*WIDTH] = {im, re};
    end
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] rnd_row();
    logic [ROW_W-1:0] r;
    for (int k = 0; k < ROW_W/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural model: phase 0=idle 1=loading 2=serving 3=dumping.
  int               m_phase = 0;
  int               m_ld_cnt = 0;
  bit               m_ok = 1'b0;
  bit               m_start = 1'b0;
  bit               m_rd_v = 1'b0;
  logic [ROW_W-1:0] m_rd_row = '0;
  int               m_rd_addr = 0;
  int               m_dump_addr = 0;
  logic [ROW_W-1:0] m_dump_row = '0;
  logic [ROW_W-1:0] m_mem [SIZE];

  wire m_ld_hs = ld_valid && m_ok && (m_phase <= 1);
  wire m_wr_hs = wr_valid && (m_phase == 2);
`ifdef MAT_ROW_BUF_BYPASS_EN
  wire m_fwd = m_wr_hs && (wr_addr == rd_addr);
`else
  wire m_fwd = 1'b0;
`endif

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ok <= 1'b0; m_phase <= 0; m_ld_cnt <= 0; m_start <= 1'b0; m_rd_v <= 1'b0;
      m_rd_row <= '0; m_rd_addr <= 0; m_dump_addr <= 0; m_dump_row <= '0;
    end else begin
      m_ok <= 1'b1;
      if (flush) begin
        m_phase <= 0; m_ld_cnt <= 0; m_start <= 1'b0; m_rd_v <= 1'b0; m_dump_addr <= 0;
      end else begin
        m_start <= 1'b0;
        m_rd_v  <= (m_phase == 2) && rd_av;
        if (m_phase == 2 && rd_av) begin
          m_rd_addr <= int'(rd_addr);
          m_rd_row  <= m_fwd ? wr_row : m_mem[rd_addr];
        end
        if (m_ld_hs) begin
          m_mem[m_ld_cnt] <= ld_row;
          if (m_ld_cnt == SIZE-1) begin
            m_ld_cnt <= 0; m_phase <= 2; m_start <= 1'b1;
          end else begin
            m_ld_cnt <= m_ld_cnt + 1; m_phase <= 1;
          end
        end
        if (m_wr_hs) m_mem[wr_addr] <= wr_row;
        if (m_phase == 2 && dump_start) begin
          m_phase <= 3; m_dump_addr <= 0; m_dump_row <= m_mem[0];
        end else if (m_phase == 3 && dump_ready) begin
          if (m_dump_addr == SIZE-1) m_phase <= 0;
          else begin
            m_dump_addr <= m_dump_addr + 1;
            m_dump_row  <= m_mem[m_dump_addr + 1];
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chkb("ld_ready", ld_ready, m_ok && (m_phase <= 1));
      chkb("wr_ready", wr_ready, m_phase == 2);
      chkb("busy", busy, m_phase != 0);
      chkb("start", start, m_start);
      chkb("rd_valid", rd_valid, m_rd_v);
      chk("rd_addr", ROW_W'(rd_addr_q), ROW_W'(m_rd_addr));
      chk("rd_row", rd_row, m_rd_row);
      chkb("dump_valid", dump_valid, m_phase == 3);
      chk("dump_addr", ROW_W'(dump_addr), ROW_W'(m_dump_addr));
      chk("dump_row", dump_row, m_dump_row);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0]    got_addr [$];
  logic [ROW_W-1:0] got_row [$];

  task automatic do_dump(input bit toggle);
    int n;
    got_addr.delete();
    got_row.delete();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      dump_ready = toggle ? ((n % 2) == 0) : 1'b1;
      if (dump_valid && dump_ready) begin
        got_addr.push_back(dump_addr);
        got_row.push_back(dump_row);
      end
      tick();
      n++;
    end
    dump_ready = 1'b0;
    chkb("dump_finished_idle", busy, 1'b0);
    chk("dump_count", ROW_W'(got_addr.size()), ROW_W'(SIZE));
  endtask

  task automatic load_rows(input logic [ROW_W-1:0] rows [SIZE], input int n);
    for (int i = 0; i < n; i++) begin
      ld_row = rows[i];
      ld_valid = 1'b1;
      chkb("ld_ready_during_load", ld_ready, 1'b1);
      tick();
    end
    ld_valid = 1'b0;
  endtask

  logic [ROW_W-1:0] rref [SIZE];
  logic [ROW_W-1:0] nrow [SIZE];
  logic [ROW_W-1:0] w_data;

  initial begin
    // Reset
    repeat (3) tick();
    chkb("rst_ld_ready", ld_ready, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_dump_valid", dump_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    chkb("ld_ready_after_rst", ld_ready, 1'b1);

    // Load R0..R3 back-to-back
    for (int i = 0; i < SIZE; i++) rref[i] = mkrow(i);
    load_rows(rref, SIZE);
    chkb("start_pulse", start, 1'b1);
    chkb("busy_serve", busy, 1'b1);
    tick();
    chkb("start_single", start, 1'b0);

    // Single read of row 2
    rd_addr = 2'd2; rd_av = 1'b1;
    tick();
    rd_av = 1'b0;
    chkb("rd2_valid", rd_valid, 1'b1);
    chk("rd2_addr", ROW_W'(rd_addr_q), ROW_W'(2));
    chk("rd2_row", rd_row, mkrow(2));
    tick();
    chkb("rd2_valid_drop", rd_valid, 1'b0);

    // Same-cycle write and read of row 1
    w_data = rnd_row();
    wr_addr = 2'd1; wr_row = w_data; wr_valid = 1'b1;
    rd_addr = 2'd1; rd_av = 1'b1;
    chkb("wr_ready_serve", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0; rd_av = 1'b0;
`ifdef MAT_ROW_BUF_BYPASS_EN
    chk("rw_same_addr", rd_row, w_data);
`else
    chk("rw_same_addr", rd_row, mkrow(1));
`endif
    rd_av = 1'b1;
    tick();
    rd_av = 1'b0;
    chk("rd1_after_wr", rd_row, w_data);
    rref[1] = w_data;

    // Dump with ready toggling 1010...
    do_dump(1'b1);
    for (int i = 0; i < got_addr.size() && i < SIZE; i++) begin
      chk("dump_order", ROW_W'(got_addr[i]), ROW_W'(i));
      chk("dump_data", got_row[i], rref[i]);
    end
    chkb("ld_ready_after_dump", ld_ready, 1'b1);

    // Flush after two load handshakes, then a full reload
    for (int i = 0; i < SIZE; i++) nrow[i] = rnd_row();
    load_rows(rref, 2);
    chkb("busy_partial", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chkb("flush_idle", busy, 1'b0);
    chkb("flush_ld_ready", ld_ready, 1'b1);
    load_rows(nrow, SIZE);
    chkb("start_after_flush", start, 1'b1);
    tick();
    do_dump(1'b0);
    for (int i = 0; i < got_addr.size() && i < SIZE; i++)
      chk("reload_data", got_row[i], nrow[i]);

    // Reset in the middle of a dump
    load_rows(rref, SIZE);
    tick();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    dump_ready = 1'b1;
    tick();
    dump_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    chkb("mid_rst_dump_valid", dump_valid, 1'b0);
    chk("mid_rst_dump_row", dump_row, '0);
    chk("mid_rst_dump_addr", ROW_W'(dump_addr), '0);
    chk("mid_rst_rd_row", rd_row, '0);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_ld_ready", ld_ready, 1'b0);
    rst_n = 1'b1;
    chkb("ld_ready_still_low", ld_ready, 1'b0);
    tick();
    chkb("ld_ready_released", ld_ready, 1'b1);

    // Randomized soak
    for (int c = 0; c < 1500; c++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      flush      = ($urandom_range(0, 79) == 0);
      ld_valid   = $urandom_range(0, 1) == 1;
      ld_row     = rnd_row();
      rd_av      = $urandom_range(0, 1) == 1;
      rd_addr    = AW'($urandom_range(0, SIZE-1));
      wr_valid   = $urandom_range(0, 1) == 1;
      wr_addr    = ($urandom_range(0, 2) == 0) ? rd_addr : AW'($urandom_range(0, SIZE-1));
      wr_row     = rnd_row();
      dump_start = ($urandom_range(0, 14) == 0);
      dump_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    rst_n = 1'b1; flush = 1'b0; ld_valid = 1'b0; rd_av = 1'b0; wr_valid = 1'b0;
    dump_start = 1'b0; dump_ready = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
